// File: rtl/iob_timer_alarm_pkg.sv
// Shared constants for the timer alarm: config write address codes, FSM states
// and default widths.
package iob_timer_alarm_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int MISSED_W_DEF = 8;

  typedef enum logic [1:0] {
    CMP_LO = 2'd0,
    CMP_HI = 2'd1,
    PER_LO = 2'd2,
    PER_HI = 2'd3
  } waddr_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

endpackage

// File: rtl/iob_timer_alarm_if.sv
// Control/status bundle between the CSR side and the alarm; the CSR side is the
// master, the alarm block is the slave.
interface iob_timer_alarm_if
  import iob_timer_alarm_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MISSED_W = MISSED_W_DEF
);

  logic                  cke_i;
  logic [2*DATA_W-1:0]   time_i;
  logic                  wen_i;
  logic [1:0]            waddr_i;
  logic [DATA_W-1:0]     wdata_i;
  logic                  mode_i;
  logic                  arm_i;
  logic                  disarm_i;
  logic                  ack_i;
  logic                  armed_o;
  logic                  pending_o;
  logic                  irq_o;
  logic [MISSED_W-1:0]   missed_o;

  modport master (
    output cke_i, time_i, wen_i, waddr_i, wdata_i, mode_i, arm_i, disarm_i, ack_i,
    input  armed_o, pending_o, irq_o, missed_o
  );

  modport slave (
    input  cke_i, time_i, wen_i, waddr_i, wdata_i, mode_i, arm_i, disarm_i, ack_i,
    output armed_o, pending_o, irq_o, missed_o
  );

endinterface

// File: rtl/iob_timer_alarm_wreg.sv
// Double-width config register: the low word waits in a shadow until the high
// word arrives, so the compare logic never sees a half-written value.
module iob_timer_alarm_wreg #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                cke,
  input  logic                wen_lo,
  input  logic                wen_hi,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                load,
  input  logic [2*DATA_W-1:0] load_data,
  output logic [2*DATA_W-1:0] value
);

  logic [DATA_W-1:0] shadow;

  // NOTE: the shadow is a plain flop, not RAM, so it is reset along with the
  // committed value; a hi write without a prior lo write then commits a known 0.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      shadow <= '0;
      value  <= '0;
    end else if (cke) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (wen_lo) shadow <= wdata;
      // A software commit outranks the hardware auto-reload.
      if (wen_hi)    value <= {wdata, shadow};
      else if (load) value <= load_data;
    end
  end

endmodule

// File: rtl/iob_timer_alarm.sv
// Alarm comparator: watches the live time count against a programmable compare
// value, with one-shot or auto-reloading periodic operation and a missed-hit count.
module iob_timer_alarm
  import iob_timer_alarm_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MISSED_W = MISSED_W_DEF
) (
  input  logic             clk_i,
  input  logic             arst_i,
  iob_timer_alarm_if.slave bus
);

  localparam int TW = 2 * DATA_W;
  localparam logic [MISSED_W-1:0] MISSED_MAX = '1;

  state_e              state;
  logic                mode_q;
  logic                pending_q;
  logic                wrap_q;
  logic [MISSED_W-1:0] missed_q;

  logic [TW-1:0] cmp;
  logic [TW-1:0] period;
  logic [TW-1:0] cmp_next;
  logic          carry;
  logic          hit;
  logic          reload;
  logic          wen_cmp_lo, wen_cmp_hi, wen_per_lo, wen_per_hi;

  always_comb begin
    // NOTE: every signal gets a default first so no path through here infers a latch.
    wen_cmp_lo = 1'b0;
    wen_cmp_hi = 1'b0;
    wen_per_lo = 1'b0;
    wen_per_hi = 1'b0;
    if (bus.wen_i) begin
      unique case (waddr_e'(bus.waddr_i))
        CMP_LO: wen_cmp_lo = 1'b1;
        CMP_HI: wen_cmp_hi = 1'b1;
        PER_LO: wen_per_lo = 1'b1;
        PER_HI: wen_per_hi = 1'b1;
      endcase
    end
  end

  // wrap_q blocks hits after the reload overflowed until time itself wraps.
  assign hit                = (state == ARMED) && !wrap_q && (bus.time_i >= cmp);
  assign {carry, cmp_next}  = {1'b0, cmp} + {1'b0, period};
  assign reload             = hit && mode_q && (period != '0);

  iob_timer_alarm_wreg #(.DATA_W(DATA_W)) u_cmp (
    .clk       (clk_i),
    .arst      (arst_i),
    .cke       (bus.cke_i),
    .wen_lo    (wen_cmp_lo),
    .wen_hi    (wen_cmp_hi),
    .wdata     (bus.wdata_i),
    .load      (reload),
    .load_data (cmp_next),
    .value     (cmp)
  );

  iob_timer_alarm_wreg #(.DATA_W(DATA_W)) u_period (
    .clk       (clk_i),
    .arst      (arst_i),
    .cke       (bus.cke_i),
    .wen_lo    (wen_per_lo),
    .wen_hi    (wen_per_hi),
    .wdata     (bus.wdata_i),
    .load      (1'b0),
    .load_data ({TW{1'b0}}),
    .value     (period)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      pending_q <= 1'b0;
      missed_q  <= '0;
      wrap_q    <= 1'b0;
    end else if (bus.cke_i) begin
      if (bus.disarm_i) begin
        state <= IDLE;
      end else begin
        if (bus.arm_i) mode_q <= bus.mode_i;
        if (state == IDLE && bus.arm_i) state <= ARMED;
        else if (hit && !reload)        state <= IDLE;
      end

      if (hit) begin
        pending_q <= 1'b1;
        if (bus.ack_i)                                missed_q <= '0;
        else if (pending_q && missed_q != MISSED_MAX) missed_q <= missed_q + MISSED_W'(1);
      end else if (bus.ack_i) begin
        pending_q <= 1'b0;
        missed_q  <= '0;
      end

      if (wen_cmp_hi)                    wrap_q <= 1'b0;
      else if (reload)                   wrap_q <= carry;
      else if (wrap_q && bus.time_i < cmp) wrap_q <= 1'b0;
    end
  end

  assign bus.armed_o   = (state == ARMED);
  assign bus.pending_o = pending_q;
  assign bus.irq_o     = pending_q;
  assign bus.missed_o  = missed_q;

endmodule

// File: tb/tb_iob_timer_alarm.sv
// Directed bench for iob_timer_alarm with a behavioural alarm model compared
// against the DUT every cycle, plus literal expectations per scenario.
module tb_iob_timer_alarm;
  import iob_timer_alarm_pkg::*;

  localparam int DW = 32;
  localparam int MW = 8;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cmp_en   = 1'b0;

  iob_timer_alarm_if #(.DATA_W(DW), .MISSED_W(MW)) bus ();

  iob_timer_alarm #(.DATA_W(DW), .MISSED_W(MW)) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the alarm described as "what the spec says happens this cycle".
  bit          m_armed, m_mode, m_pend, m_wrap;
  int          m_missed;
  logic [63:0] m_cmp, m_per;
  logic [31:0] m_sh_cmp, m_sh_per;

  task automatic model_reset();
    m_armed = 0; m_mode = 0; m_pend = 0; m_wrap = 0; m_missed = 0;
    m_cmp = '0; m_per = '0; m_sh_cmp = '0; m_sh_per = '0;
  endtask

  task automatic model_step();
    logic [63:0] t, n_cmp;
    bit fire, n_wrap, n_armed;
    t       = bus.time_i;
    fire    = m_armed && !m_wrap && (t >= m_cmp);
    n_cmp   = m_cmp;
    n_armed = m_armed;
    n_wrap  = m_wrap && (t >= m_cmp);
    if (fire) begin
      if (m_mode && m_per != 0) begin
        n_cmp  = m_cmp + m_per;
        n_wrap = (n_cmp < m_cmp);
      end else begin
        n_armed = 0;
      end
      if (bus.ack_i)                      m_missed = 0;
      else if (m_pend && m_missed < 255)  m_missed = m_missed + 1;
      m_pend = 1;
    end else if (bus.ack_i) begin
      m_pend = 0;
      m_missed = 0;
    end
    if (bus.wen_i) begin
      case (bus.waddr_i)
        2'd0: m_sh_cmp = bus.wdata_i;
        2'd1: begin n_cmp = {bus.wdata_i, m_sh_cmp}; n_wrap = 0; end
        2'd2: m_sh_per = bus.wdata_i;
        default: m_per = {bus.wdata_i, m_sh_per};
      endcase
    end
    if (bus.disarm_i) n_armed = 0;
    else if (bus.arm_i) begin
      m_mode = bus.mode_i;
      if (!m_armed) n_armed = 1;
    end
    m_cmp = n_cmp; m_wrap = n_wrap; m_armed = n_armed;
  endtask

  always @(posedge clk or posedge arst) begin
    if (arst)           model_reset();
    else if (bus.cke_i) model_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_armed",   bus.armed_o,   m_armed);
      check("cyc_pending", bus.pending_o, m_pend);
      check("cyc_irq",     bus.irq_o,     m_pend);
      check("cyc_missed",  bus.missed_o,  m_missed[MW-1:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus.wen_i = 1'b1; bus.waddr_i = addr; bus.wdata_i = data;
    tick();
    bus.wen_i = 1'b0;
  endtask

  initial begin
    bus.cke_i = 1'b1; bus.time_i = '0; bus.wen_i = 1'b0; bus.waddr_i = '0; bus.wdata_i = '0;
    bus.mode_i = 1'b0; bus.arm_i = 1'b0; bus.disarm_i = 1'b0; bus.ack_i = 1'b0;
    #1 arst = 1'b1;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    cmp_en = 1'b1;
    check("rst_armed",   bus.armed_o,   0);
    check("rst_pending", bus.pending_o, 0);
    check("rst_missed",  bus.missed_o,  0);

    // 1: one-shot at 100
    wr(CMP_LO, 100); wr(CMP_HI, 0);
    bus.time_i = 50; bus.mode_i = 1'b0; bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0;
    check("t1_armed", bus.armed_o, 1);
    for (int v = 51; v <= 110; v++) begin
      bus.time_i = v;
      tick();
      if (v == 99) check("t1_before_hit", bus.pending_o, 0);
      if (v == 100) begin
        check("t1_hit", bus.pending_o, 1);
        check("t1_idle_after_hit", bus.armed_o, 0);
      end
    end
    check("t1_no_more_hits", bus.missed_o, 0);
    bus.ack_i = 1'b1; tick(); bus.ack_i = 1'b0;
    check("t1_ack", bus.pending_o, 0);

    // 2: periodic 100 + k*10, no ack
    wr(PER_LO, 10); wr(PER_HI, 0); wr(CMP_LO, 100); wr(CMP_HI, 0);
    bus.time_i = 0; bus.mode_i = 1'b1; bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0;
    for (int v = 1; v <= 125; v++) begin bus.time_i = v; tick(); end
    check("t2_pending", bus.pending_o, 1);
    check("t2_missed",  bus.missed_o,  2);
    check("t2_armed",   bus.armed_o,   1);
    bus.ack_i = 1'b1; tick(); bus.ack_i = 1'b0;
    check("t2_ack_pending", bus.pending_o, 0);
    check("t2_ack_missed",  bus.missed_o,  0);
    bus.disarm_i = 1'b1; tick(); bus.disarm_i = 1'b0;
    check("t2_disarm", bus.armed_o, 0);

    // 3: lo write alone must not disturb the live compare value
    wr(CMP_LO, 1000); wr(CMP_HI, 0);
    bus.time_i = 3; bus.mode_i = 1'b0; bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0;
    for (int v = 3; v <= 10; v++) begin
      bus.time_i = v;
      if (v == 6) begin bus.wen_i = 1'b1; bus.waddr_i = CMP_LO; bus.wdata_i = 5; end
      tick();
      bus.wen_i = 1'b0;
    end
    check("t3_no_early_hit", bus.pending_o, 0);
    wr(CMP_HI, 0);
    check("t3_commit_cycle", bus.pending_o, 0);
    tick();
    check("t3_hit_after_commit", bus.pending_o, 1);
    check("t3_oneshot_idle",     bus.armed_o,   0);

    // 4: reload overflow sets wrap
    bus.ack_i = 1'b1; tick(); bus.ack_i = 1'b0;
    wr(PER_LO, 10); wr(PER_HI, 0); wr(CMP_LO, 32'hFFFF_FFFB); wr(CMP_HI, 32'hFFFF_FFFF);
    bus.time_i = 64'hFFFF_FFFF_FFFF_FFF8; bus.mode_i = 1'b1; bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0;
    for (int i = 1; i <= 7; i++) begin bus.time_i = 64'hFFFF_FFFF_FFFF_FFF8 + 64'(i); tick(); end
    check("t4_hit_top",        bus.pending_o, 1);
    check("t4_wrap_suppress",  bus.missed_o,  0);
    for (int v = 0; v <= 4; v++) begin bus.time_i = v; tick(); end
    check("t4_no_hit_below_5", bus.missed_o,  0);
    bus.time_i = 5; tick();
    check("t4_hit_post_wrap",  bus.missed_o,  1);
    check("t4_still_armed",    bus.armed_o,   1);

    // 5: collisions and saturation
    bus.ack_i = 1'b1; bus.disarm_i = 1'b1; tick(); bus.ack_i = 1'b0; bus.disarm_i = 1'b0;
    bus.arm_i = 1'b1; bus.disarm_i = 1'b1; tick(); bus.arm_i = 1'b0; bus.disarm_i = 1'b0;
    check("t5_disarm_wins", bus.armed_o, 0);
    wr(PER_LO, 1); wr(PER_HI, 0); wr(CMP_LO, 100); wr(CMP_HI, 0);
    bus.time_i = 1000; bus.mode_i = 1'b1; bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0;
    repeat (4) tick();
    check("t5_catchup_missed", bus.missed_o, 3);
    bus.ack_i = 1'b1; tick(); bus.ack_i = 1'b0;
    check("t5_ack_hit_pending", bus.pending_o, 1);
    check("t5_ack_hit_missed",  bus.missed_o,  0);
    repeat (300) tick();
    check("t5_saturate", bus.missed_o, 255);

    // 6: async reset mid-ARMED, then clock-enable freeze
    @(negedge clk);
    #2 arst = 1'b1;
    #1;
    check("t6_arst_armed",   bus.armed_o,   0);
    check("t6_arst_pending", bus.pending_o, 0);
    check("t6_arst_irq",     bus.irq_o,     0);
    check("t6_arst_missed",  bus.missed_o,  0);
    @(posedge clk);
    #1 arst = 1'b0;
    bus.time_i = 50; bus.mode_i = 1'b0; bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0;
    check("t6_armed", bus.armed_o, 1);
    bus.cke_i = 1'b0; bus.disarm_i = 1'b1;
    repeat (3) tick();
    bus.disarm_i = 1'b0;
    check("t6_cke_hold_armed",   bus.armed_o,   1);
    check("t6_cke_hold_pending", bus.pending_o, 0);
    bus.cke_i = 1'b1; tick();
    check("t6_cke_resume_hit",  bus.pending_o, 1);
    check("t6_cke_resume_idle", bus.armed_o,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
